img_pad: RTL and testbench

Inverse of the crop stage: an AXI4-Stream video block that grows each frame by inserting constant-value border pixels (top, bottom, left, right) around an incoming 1 pixel-per-clock image. It sits in the same video pipeline as the crop block and emits a stream with identical framing conventions: tuser[0] marks start of frame, tlast marks end of line. The block is built around a frame/line FSM that stalls the input while it generates border beats.

---
 rtl/img_pad.sv | 114 +++++++++++
 tb/tb_img_pad.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_pad.sv
// img_pad: AXI4-Stream frame padder that surrounds each incoming image with a
// constant-value border, stalling the input while border beats are generated.
module img_pad #(
    parameter int TUSER_WIDTH = 5,
    parameter int TDEST_WIDTH = 2,
    parameter int TDATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            in_width,
    input  logic [11:0]            in_height,
    input  logic [11:0]            pad_left,
    input  logic [11:0]            pad_right,
    input  logic [11:0]            pad_top,
    input  logic [11:0]            pad_bottom,
    input  logic [TDATA_WIDTH-1:0] pad_value,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   err
);
    typedef enum logic [2:0] {IDLE, PAD_ROW, PAD_L, PASS, PAD_R} state_t;

    state_t state, state_nxt, eol_next, line_first;
    logic [11:0] w, pl, pr;
    logic [12:0] pt, img_end, ow, oh;
    logic [TDATA_WIDTH-1:0] pv;
    logic [TUSER_WIDTH-1:1] user_hi;
    logic [TDEST_WIDTH-1:0] dest;
    logic [12:0] x_out, y_out, next_y;
    logic [11:0] x_in;
    logic load, sof_in, cfg_ok, fire, eol, last_line, last_px, first_px, img_next, pass_acc;

    assign load       = !m_axis_tvalid || m_axis_tready;
    assign sof_in     = s_axis_tvalid && s_axis_tuser[0];
    assign cfg_ok     = in_width != '0 && in_height != '0;
    assign eol        = x_out == ow - 13'd1;
    assign last_line  = y_out == oh - 13'd1;
    assign last_px    = x_in == w - 12'd1;
    assign first_px   = x_in == '0 && y_out == pt;
    assign next_y     = y_out + 13'd1;
    assign img_next   = next_y >= pt && next_y < img_end;
    assign line_first = pl != '0 ? PAD_L : PASS;
    assign eol_next   = last_line ? IDLE : img_next ? line_first : PAD_ROW;
    assign pass_acc   = state == PASS && s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sof_in && cfg_ok) state_nxt = pad_top != '0 ? PAD_ROW : pad_left != '0 ? PAD_L : PASS;
            PAD_ROW: if (fire && eol) state_nxt = eol_next;
            PAD_L:   if (fire && x_out == {1'b0, pl} - 13'd1) state_nxt = PASS;
            PASS:    if (fire && last_px) state_nxt = pr != '0 ? PAD_R : eol_next;
            PAD_R:   if (fire && eol) state_nxt = eol_next;
            default: state_nxt = IDLE;
        endcase
    end

    // The SOF beat is left waiting in IDLE so PASS can forward it as the first image pixel.
    always_comb begin
        s_axis_tready = rst_n && (state == PASS ? load : state == IDLE && !sof_in && cfg_ok);
        fire          = load && (state == PASS ? s_axis_tvalid : state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w <= '0; pl <= '0; pr <= '0; pt <= '0; img_end <= '0; ow <= '0; oh <= '0;
            pv <= '0; user_hi <= '0; dest <= '0;
            x_out <= '0; y_out <= '0; x_in <= '0;
            m_axis_tvalid <= 1'b0; m_axis_tlast <= 1'b0; m_axis_tuser <= '0;
            m_axis_tdest <= '0; m_axis_tdata <= '0; err <= 1'b0;
        end else begin
            if (state == IDLE && sof_in && cfg_ok) begin
                w       <= in_width;
                pl      <= pad_left;
                pr      <= pad_right;
                pt      <= {1'b0, pad_top};
                img_end <= {1'b0, pad_top} + {1'b0, in_height};
                ow      <= {1'b0, in_width} + {1'b0, pad_left} + {1'b0, pad_right};
                oh      <= {1'b0, in_height} + {1'b0, pad_top} + {1'b0, pad_bottom};
                pv      <= pad_value;
                user_hi <= s_axis_tuser[TUSER_WIDTH-1:1];
                dest    <= s_axis_tdest;
            end
            if (fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= state == PASS ? s_axis_tdata : pv;
                m_axis_tuser  <= {user_hi, x_out == '0 && y_out == '0};
                m_axis_tdest  <= dest;
                m_axis_tlast  <= eol;
                x_out         <= eol ? '0 : x_out + 13'd1;
                y_out         <= eol ? (last_line ? '0 : next_y) : y_out;
                if (state == PASS) x_in <= last_px ? '0 : x_in + 12'd1;
            end else if (load) begin
                m_axis_tvalid <= 1'b0;
            end
            err <= pass_acc && (s_axis_tlast != last_px || (s_axis_tuser[0] && !first_px));
        end
    end
endmodule

// File: tb/tb_img_pad.sv
// tb_img_pad: directed table-driven bench for img_pad covering padding, passthrough,
// back-pressure, framing errors, pre-SOF drops and mid-frame reset.
module tb_img_pad;
    typedef struct packed {logic [7:0] d; logic sof; logic last;} beat_t;
    typedef struct {logic [7:0] d; logic [4:0] u; logic l; logic [1:0] dst; int c;} obs_t;
    localparam logic [1:0] N = 2'b00, S = 2'b10, L = 2'b01;

    logic clk, rst_n;
    logic [11:0] in_w, in_h, p_l, p_r, p_t, p_b;
    logic [7:0] p_v, s_data, m_data;
    logic [4:0] s_user, m_user;
    logic [1:0] s_dest, m_dest;
    logic s_valid, s_ready, s_last, m_valid, m_ready, m_last, err;

    int checks = 0, errors = 0, cyc = 0, last_waits = 0;
    int stalls, stab_viol, err_cnt, err_cyc;
    logic rnd = 1'b0;
    logic [3:0] hi;
    logic [1:0] dst;
    obs_t q[$];
    int acc_q[$];
    beat_t ins[$], exps[$];

    beat_t t1_in[8] = '{{8'h01,S},{8'h02,N},{8'h03,N},{8'h04,L},{8'h05,N},{8'h06,N},{8'h07,N},{8'h08,L}};
    beat_t t1_exp[24] = '{
        {8'hAA,S},{8'hAA,N},{8'hAA,N},{8'hAA,N},{8'hAA,N},{8'hAA,L},
        {8'hAA,N},{8'h01,N},{8'h02,N},{8'h03,N},{8'h04,N},{8'hAA,L},
        {8'hAA,N},{8'h05,N},{8'h06,N},{8'h07,N},{8'h08,N},{8'hAA,L},
        {8'hAA,N},{8'hAA,N},{8'hAA,N},{8'hAA,N},{8'hAA,N},{8'hAA,L}};
    beat_t t2[9] = '{{8'h10,S},{8'h11,N},{8'h12,L},{8'h13,N},{8'h14,N},{8'h15,L},{8'h16,N},{8'h17,N},{8'h18,L}};
    beat_t t4_in[4] = '{{8'h31,S},{8'h32,N},{8'h41,S},{8'h42,L}};
    beat_t t4_exp[8] = '{{8'hAA,S},{8'h31,N},{8'h32,N},{8'hAA,L},{8'hAA,S},{8'h41,N},{8'h42,N},{8'hAA,L}};
    beat_t t5_pre[3] = '{{8'hE1,N},{8'hE2,N},{8'hE3,N}};
    beat_t t5_in[2] = '{{8'h51,S},{8'h52,L}};
    beat_t t5_exp[4] = '{{8'hAA,S},{8'h51,N},{8'h52,N},{8'hAA,L}};

    img_pad #(.TUSER_WIDTH(5), .TDEST_WIDTH(2), .TDATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_width(in_w), .in_height(in_h),
        .pad_left(p_l), .pad_right(p_r), .pad_top(p_t), .pad_bottom(p_b), .pad_value(p_v),
        .s_axis_tuser(s_user), .s_axis_tdest(s_dest), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tdata(s_data),
        .m_axis_tuser(m_user), .m_axis_tdest(m_dest), .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tdata(m_data),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Collects handshaken output beats, err pulses and stall-stability violations.
    initial begin
        logic [15:0] held;
        logic held_v;
        held_v = 1'b0; held = '0;
        stalls = 0; stab_viol = 0; err_cnt = 0; err_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n && held_v) begin
                stalls++;
                if (!m_valid || {m_data, m_user, m_last, m_dest} != held) stab_viol++;
            end
            held_v = rst_n && m_valid && !m_ready;
            held = {m_data, m_user, m_last, m_dest};
            if (rst_n && m_valid && m_ready) q.push_back('{m_data, m_user, m_last, m_dest, cyc});
            if (rst_n && err) begin err_cnt++; err_cyc = cyc; end
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, got, exp);
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int l, input int r, input int t, input int b);
        in_w = 12'(w); in_h = 12'(h); p_l = 12'(l); p_r = 12'(r); p_t = 12'(t); p_b = 12'(b);
        p_v = 8'hAA;
    endtask

    task automatic send(input beat_t b, input int gap);
        int w;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        s_valid = 1'b1; s_data = b.d; s_last = b.last;
        s_user = {b.sof ? hi : 4'h0, b.sof};
        s_dest = b.sof ? dst : 2'd0;
        w = 0;
        while (w <= 500) begin
            @(negedge clk);
            if (s_ready) break;
            w++;
        end
        if (w > 500) begin
            checks++; errors++;
            $display("FAIL send timeout: beat 0x%0h not accepted, want accept within 500 cycles", b.d);
        end
        last_waits = w;
        acc_q.push_back(cyc);
        @(posedge clk); #1;
    endtask

    task automatic drive(input int n, input int max_gap);
        for (int i = 0; i < n; i++) send(ins[i], max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
        s_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int base);
        int t;
        t = 0;
        while (q.size() < base + exps.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, " count"}, 32'(q.size() - base), 32'(exps.size()));
        for (int i = 0; i < exps.size() && base + i < q.size(); i++)
            chk($sformatf("%s beat %0d", tag, i),
                32'({q[base+i].d, q[base+i].u, q[base+i].l, q[base+i].dst}),
                32'({exps[i].d, hi, exps[i].sof, exps[i].last, dst}));
        @(posedge clk); #1;
    endtask

    task automatic load_t1;
        ins.delete(); exps.delete();
        foreach (t1_in[i]) ins.push_back(t1_in[i]);
        foreach (t1_exp[i]) exps.push_back(t1_exp[i]);
    endtask

    initial begin
        int qb, ab, e0, v0, s0;
        rst_n = 1'b0; s_valid = 1'b0; s_user = '0; s_dest = '0; s_last = 1'b0; s_data = '0;
        set_cfg(4, 2, 1, 1, 1, 1);
        hi = 4'hA; dst = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst m_tvalid", 32'(m_valid), 0);
        chk("rst m_tlast", 32'(m_last), 0);
        chk("rst m_tuser", 32'(m_user), 0);
        chk("rst m_tdest", 32'(m_dest), 0);
        chk("rst m_tdata", 32'(m_data), 0);
        chk("rst err", 32'(err), 0);
        chk("rst s_tready", 32'(s_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 4x2 image with one-pixel border on every side
        load_t1();
        qb = q.size(); e0 = err_cnt;
        drive(8, 0);
        check_out("pad4x2", qb);
        if (q.size() >= qb + 24) chk("pad4x2 24 consecutive beats", 32'(q[qb+23].c - q[qb].c), 23);
        chk("pad4x2 no err", 32'(err_cnt - e0), 0);

        // zero padding: plain passthrough with one-cycle latency
        set_cfg(3, 3, 0, 0, 0, 0);
        hi = 4'h5; dst = 2'd1;
        ins.delete(); exps.delete();
        foreach (t2[i]) begin ins.push_back(t2[i]); exps.push_back(t2[i]); end
        qb = q.size(); ab = acc_q.size();
        drive(9, 0);
        check_out("pass3x3", qb);
        for (int i = 0; i < 9 && qb + i < q.size(); i++)
            chk($sformatf("pass3x3 latency %0d", i), 32'(q[qb+i].c - acc_q[ab+i]), 1);

        // back-pressure and input gaps must not change the stream
        set_cfg(4, 2, 1, 1, 1, 1);
        hi = 4'h6; dst = 2'd3;
        load_t1();
        qb = q.size(); v0 = stab_viol; s0 = stalls;
        rnd = 1'b1;
        drive(8, 2);
        check_out("stall", qb);
        rnd = 1'b0;
        chk("stall output stable", 32'(stab_viol - v0), 0);
        chk("stall exercised", 32'(stalls - s0 > 0), 1);

        // missing tlast on the first frame's last pixel
        set_cfg(2, 1, 1, 1, 0, 0);
        hi = 4'h3; dst = 2'd0;
        ins.delete(); exps.delete();
        foreach (t4_in[i]) ins.push_back(t4_in[i]);
        foreach (t4_exp[i]) exps.push_back(t4_exp[i]);
        qb = q.size(); ab = acc_q.size(); e0 = err_cnt;
        drive(4, 0);
        check_out("tlasterr", qb);
        chk("tlasterr err pulses", 32'(err_cnt - e0), 1);
        chk("tlasterr err timing", 32'(err_cyc), 32'(acc_q[ab+1] + 1));

        // non-SOF beats before the frame are swallowed
        hi = 4'h9; dst = 2'd2;
        qb = q.size();
        foreach (t5_pre[i]) begin
            send(t5_pre[i], 0);
            chk($sformatf("drop beat %0d accepted at once", i), 32'(last_waits), 0);
        end
        ins.delete(); exps.delete();
        foreach (t5_in[i]) ins.push_back(t5_in[i]);
        foreach (t5_exp[i]) exps.push_back(t5_exp[i]);
        drive(2, 0);
        check_out("predrop", qb);

        // reset during the right border of the first image line
        set_cfg(4, 2, 1, 1, 1, 1);
        hi = 4'hC; dst = 2'd1;
        load_t1();
        drive(4, 0);
        chk("mid state PAD_R", 32'(dut.state), 4);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst m_tvalid", 32'(m_valid), 0);
        chk("midrst state IDLE", 32'(dut.state), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        qb = q.size();
        drive(8, 0);
        check_out("after_rst", qb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
